// File: rtl/forloop_pattern_gen.sv
// forloop_pattern_gen
// Multi-channel pattern generator built from nested genvar loops. On a start
// request in IDLE, every enabled lane loads a phase-shifted alternating seed
// (bit j of lane k = (j+k)%2). The generator then applies len updates in one
// of four modes (ALT, CNT, WALK, HOLD) before pulsing done for one cycle.
//
// Optional feature: define FORLOOP_PATTERN_GEN_PARITY_EN to add the par output.
// par[k] holds the registered even parity of lane k, so par[k] == ^a_k in
// every cycle.
//
// Ports:
//   c      clock, rising edge
//   rn     asynchronous active-low reset
//   start  run request, sampled in IDLE only
//   mode   update mode, latched at start: 0 ALT, 1 CNT, 2 WALK, 3 HOLD
//   ch_en  per-channel enable, latched at start
//   len    number of update cycles, latched at start
//   busy   high while running
//   done   one-cycle completion pulse
//   a      packed lanes; channel k is a[k*W +: W]
//   par    per-lane parity (only with FORLOOP_PATTERN_GEN_PARITY_EN)
module forloop_pattern_gen #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned LW   = 8
) (
  input  logic              c,
  input  logic              rn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [LW-1:0]     len,
  output logic              busy,
  output logic              done,
  output logic [N_CH*W-1:0] a
`ifdef FORLOOP_PATTERN_GEN_PARITY_EN
  ,
  output logic [N_CH-1:0]   par
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [1:0] ModeAlt  = 2'd0;
  localparam logic [1:0] ModeCnt  = 2'd1;
  localparam logic [1:0] ModeWalk = 2'd2;
  localparam logic [1:0] ModeHold = 2'd3;

  localparam logic [LW-1:0] LenOne  = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  LaneOne = {{(W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [LW-1:0]       cnt_q, cnt_d;
  logic [LW-1:0]       len_q, len_d;
  logic [1:0]          mode_q, mode_d;
  logic [N_CH-1:0]     ch_en_q, ch_en_d;
  logic [N_CH*W-1:0]   a_q, a_d;
  logic                busy_q, done_q;

  logic load;
  logic run;
  logic last_run;

  assign load     = (state_q == StIdle) && start;
  assign run      = (state_q == StRun);
  // len_q is never zero in RUN, so len_q - 1 cannot underflow here.
  assign last_run = run && (cnt_q == (len_q - LenOne));

  // Control FSM: latches the run configuration and counts update cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    ch_en_d = ch_en_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          ch_en_d = ch_en;
          len_d   = len;
          cnt_d   = '0;
          state_d = (len != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        cnt_d = cnt_q + LenOne;
        if (last_run) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef FORLOOP_PATTERN_GEN_PARITY_EN
  logic [N_CH-1:0] par_q, par_d;
`endif

  // Per-lane datapath: seed constant from a nested bit loop, next-value mux.
  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic [W-1:0] seed;
    logic [W-1:0] cur;
    logic [W-1:0] nxt;

    for (genvar j = 0; j < W; j++) begin : g_bit
      localparam logic SeedBit = (((j + k) % 2) == 1);
      assign seed[j] = SeedBit;
    end

    assign cur = a_q[k*W +: W];

    always_comb begin
      nxt = cur;
      if (load && ch_en[k]) begin
        nxt = seed;
      end else if (run && ch_en_q[k]) begin
        unique case (mode_q)
          ModeAlt:  nxt = ~cur;
          ModeCnt:  nxt = cur + LaneOne;
          ModeWalk: nxt = {cur[W-2:0], cur[W-1]};
          ModeHold: nxt = cur;
          default:  nxt = cur;
        endcase
      end
    end

    assign a_d[k*W +: W] = nxt;

`ifdef FORLOOP_PATTERN_GEN_PARITY_EN
    // Parity of the value being registered, so it lines up with a on the same edge.
    assign par_d[k] = ^nxt;
`endif
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= '0;
      ch_en_q <= '0;
      a_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      ch_en_q <= ch_en_d;
      a_q     <= a_d;
      busy_q  <= (state_d == StRun);
      done_q  <= (state_d == StDone);
    end
  end

`ifdef FORLOOP_PATTERN_GEN_PARITY_EN
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      par_q <= '0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par = par_q;
`endif

  assign a    = a_q;
  assign busy = busy_q;
  assign done = done_q;

  // busy and done are mutually exclusive, and done never lasts two cycles.
  assert property (@(posedge c) disable iff (!rn) !(busy_q && done_q));
  assert property (@(posedge c) disable iff (!rn) done_q |=> !done_q);

endmodule

// File: tb/tb_forloop_pattern_gen.sv
// Self-checking bench for forloop_pattern_gen: directed cases plus randomized
// runs against a closed-form lane model (value after n updates per mode).
module tb_forloop_pattern_gen;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int LW   = 8;

  logic              c = 1'b0;
  logic              rn;
  logic              start;
  logic [1:0]        mode;
  logic [N_CH-1:0]   ch_en;
  logic [LW-1:0]     len;
  logic              busy;
  logic              done;
  logic [N_CH*W-1:0] a;
`ifdef FORLOOP_PATTERN_GEN_PARITY_EN
  logic [N_CH-1:0]   par;
`endif

  forloop_pattern_gen #(
    .N_CH(N_CH),
    .W   (W),
    .LW  (LW)
  ) dut (
    .c    (c),
    .rn   (rn),
    .start(start),
    .mode (mode),
    .ch_en(ch_en),
    .len  (len),
    .busy (busy),
    .done (done),
    .a    (a)
`ifdef FORLOOP_PATTERN_GEN_PARITY_EN
    ,
    .par  (par)
`endif
  );

  always #5 c = ~c;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: lane values at the start of the current run.
  logic [W-1:0]    base [N_CH];
  logic [N_CH-1:0] en_lat;
  logic [1:0]      mode_lat;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] seed_of(input int k);
    logic [W-1:0] s;
    for (int j = 0; j < W; j++) s[j] = (((j + k) % 2) == 1);
    return s;
  endfunction

  // Lane value after n updates, computed directly from the mode rule.
  function automatic logic [W-1:0] after_n(input logic [W-1:0] v, input logic [1:0] m,
                                           input int n);
    int r;
    case (m)
      2'd0: return (n % 2 == 1) ? ~v : v;
      2'd1: return v + W'(n);
      2'd2: begin
        r = n % W;
        if (r == 0) return v;
        return (v << r) | (v >> (W - r));
      end
      default: return v;
    endcase
  endfunction

  function automatic logic [N_CH*W-1:0] expect_bus(input int n);
    logic [N_CH*W-1:0] e;
    for (int k = 0; k < N_CH; k++)
      e[k*W +: W] = en_lat[k] ? after_n(base[k], mode_lat, n) : base[k];
    return e;
  endfunction

  task automatic check_outputs(input string tag, input int n, input logic exp_busy,
                               input logic exp_done);
    logic [N_CH*W-1:0] e;
    e = expect_bus(n);
    check_eq({tag, ".a"}, 64'(a), 64'(e));
    check_eq({tag, ".busy"}, 64'(busy), 64'(exp_busy));
    check_eq({tag, ".done"}, 64'(done), 64'(exp_done));
`ifdef FORLOOP_PATTERN_GEN_PARITY_EN
    begin
      logic [N_CH-1:0] ep;
      for (int k = 0; k < N_CH; k++) ep[k] = ^e[k*W +: W];
      check_eq({tag, ".par"}, 64'(par), 64'(ep));
    end
`endif
  endtask

  task automatic model_clear();
    for (int k = 0; k < N_CH; k++) base[k] = '0;
    en_lat   = '0;
    mode_lat = '0;
  endtask

  task automatic do_reset();
    @(negedge c);
    rn    = 1'b0;
    start = 1'b0;
    #1;
    model_clear();
    check_outputs("reset", 0, 1'b0, 1'b0);
    @(negedge c);
    rn = 1'b1;
  endtask

  // One complete run; poke (1..l) raises start mid-run to prove it is ignored.
  task automatic do_run(input logic [1:0] m, input logic [N_CH-1:0] en, input int l,
                        input int poke);
    @(negedge c);
    start = 1'b1;
    mode  = m;
    ch_en = en;
    len   = LW'(l);
    @(posedge c);
    #1;
    start = 1'b0;
    // Scramble inputs after the latch edge; the DUT must use latched copies.
    mode  = 2'($urandom);
    ch_en = N_CH'($urandom);
    len   = LW'($urandom);
    mode_lat = m;
    en_lat   = en;
    for (int k = 0; k < N_CH; k++) if (en[k]) base[k] = seed_of(k);
    @(negedge c);
    if (l == 0) begin
      check_outputs("len0", 0, 1'b0, 1'b1);
    end else begin
      check_outputs("seed", 0, 1'b1, 1'b0);
      for (int i = 1; i <= l; i++) begin
        if (i == poke) start = 1'b1;
        @(posedge c);
        #1;
        start = 1'b0;
        @(negedge c);
        if (i == l) check_outputs("end", i, 1'b0, 1'b1);
        else        check_outputs("run", i, 1'b1, 1'b0);
      end
    end
    @(negedge c);
    check_outputs("idle", l, 1'b0, 1'b0);
    for (int k = 0; k < N_CH; k++) if (en_lat[k]) base[k] = after_n(base[k], mode_lat, l);
    en_lat = '0;
  endtask

  task automatic reset_mid_run();
    do_run_prefix();
    repeat (3) @(posedge c);
    @(negedge c);
    #2;
    rn = 1'b0;
    #1;
    model_clear();
    check_outputs("midrst", 0, 1'b0, 1'b0);
    #1;
    rn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge c);
      check_outputs("postrst", 0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_run_prefix();
    @(negedge c);
    start = 1'b1;
    mode  = 2'd1;
    ch_en = '1;
    len   = LW'(20);
    @(posedge c);
    #1;
    start = 1'b0;
  endtask

  initial begin
    rn    = 1'b0;
    start = 1'b0;
    mode  = '0;
    ch_en = '0;
    len   = '0;
    model_clear();

    do_reset();
    do_run(2'd0, 4'hF, 3, 0);
    check_eq("alt3_final", 64'(a), 64'h0000_0000_AA55_AA55);

    do_reset();
    do_run(2'd1, 4'b0001, 5, 0);
    check_eq("cnt5_final", 64'(a), 64'h0000_0000_0000_00AF);

    do_reset();
    do_run(2'd2, 4'hF, 1, 0);
    check_eq("walk1_final", 64'(a), 64'h0000_0000_AA55_AA55);
    do_run(2'd2, 4'hF, 8, 0);
    check_eq("walk8_final", 64'(a), 64'h0000_0000_55AA_55AA);

    do_run(2'd1, 4'b0010, 8'hAB, 50);
    check_eq("cnt_wrap_ch1", 64'(a[15:8]), 64'h0);

    do_run(2'd0, 4'hF, 0, 0);
    check_eq("len0_seeds", 64'(a), 64'h0000_0000_55AA_55AA);
    do_run(2'd3, 4'hF, 4, 0);
    check_eq("hold4_final", 64'(a), 64'h0000_0000_55AA_55AA);

    reset_mid_run();

    for (int t = 0; t < 30; t++) begin
      int l;
      int poke;
      if ($urandom_range(0, 9) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) l = int'($urandom_range(0, 255));
      else                           l = int'($urandom_range(0, 12));
      poke = (l == 0) ? 0 : int'($urandom_range(0, l));
      do_run(2'($urandom_range(0, 3)), N_CH'($urandom), l, poke);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
